ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_line_sync.sv | 37 +++
 rtl/ps2_host_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types and constants for the host transmitter and receiver.
// Holds the transmitter state encoding, command bytes and frame helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between controller logic and the transmitter.
// The controller is the master; the transmitter is the slave.
interface ps2_host_tx_if;

    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_ack_ok;
    logic       tx_error;

    modport master (
        output tx_byte,
        output tx_start,
        input  tx_busy,
        input  tx_done,
        input  tx_ack_ok,
        input  tx_error
    );

    modport slave (
        input  tx_byte,
        input  tx_start,
        output tx_busy,
        output tx_done,
        output tx_ack_ok,
        output tx_error
    );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for the PS/2 pins plus a registered
// falling-edge pulse on the clock line.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic sync_clk_o,
    output logic sync_data_o,
    output logic fall_o
);

    logic [1:0] clk_ff_q;
    logic [1:0] data_ff_q;
    logic       clk_prev_q;
    logic       fall_q;

    // Idle bus level is high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_ff_q   <= 2'b11;
            data_ff_q  <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
            data_ff_q  <= {data_ff_q[0], ps2_data_i};
            clk_prev_q <= clk_ff_q[1];
            fall_q     <= clk_prev_q & ~clk_ff_q[1];
        end
    end

    assign sync_clk_o  = clk_ff_q[1];
    assign sync_data_o = data_ff_q[1];
    assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, clocks out one framed byte and reports the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_MS  = 15
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2k_clk,
    input  logic         ps2k_data,
    output logic         ps2k_clk_oe,
    output logic         ps2k_data_oe
);

    localparam longint INH_CYC =
        longint'(INHIBIT_US) * longint'(CLK_FREQ_HZ) / 1_000_000;
    localparam longint TO_CYC =
        longint'(TIMEOUT_MS) * longint'(CLK_FREQ_HZ) / 1000;
    localparam int INH_W = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;
    localparam int TO_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [3:0] PAR_FALL = 4'(PS2_FRAME_BITS - 2);

    ps2_tx_state_e    state_q;
    logic [8:0]       frame_q;
    logic [3:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             clk_oe_q;
    logic             data_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             ack_q;
    logic             err_q;

    logic sync_clk;
    logic sync_data;
    logic sync_fall;
    logic to_run;
    logic to_hit;

    ps2_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2k_clk),
        .ps2_data_i  (ps2k_data),
        .sync_clk_o  (sync_clk),
        .sync_data_o (sync_data),
        .fall_o      (sync_fall)
    );

    // A sampled ACK on the 11th fall beats a coincident timeout.
    assign to_run = state_q inside {S_REQ, S_DATA, S_STOP, S_ACK};
    assign to_hit = to_run && (to_cnt_q == TO_LAST)
                    && !(state_q == S_ACK && sync_fall);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (to_run) to_cnt_q <= to_cnt_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (tx.tx_start) begin
                        frame_q   <= {odd_parity(tx.tx_byte), tx.tx_byte};
                        busy_q    <= 1'b1;
                        ack_q     <= 1'b0;
                        err_q     <= 1'b0;
                        inh_cnt_q <= '0;
                        clk_oe_q  <= 1'b1;
                        state_q   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt_q <= inh_cnt_q + 1'b1;
                    if (inh_cnt_q == INH_LAST - 1'b1) data_oe_q <= 1'b1;
                    if (inh_cnt_q == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        to_cnt_q  <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ, S_DATA: begin
                    if (sync_fall) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        data_oe_q <= ~frame_q[0];
                        frame_q   <= {1'b0, frame_q[8:1]};
                        state_q   <= (bit_cnt_q == PAR_FALL - 4'd1)
                                     ? S_STOP : S_DATA;
                    end
                end
                S_STOP: begin
                    if (sync_fall) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (sync_fall) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        ack_q     <= ~sync_data;
                        err_q     <= sync_data;
                        state_q   <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (sync_clk && sync_data) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (to_hit) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                ack_q     <= 1'b0;
                err_q     <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= S_DONE;
            end
        end
    end

    assign tx.tx_busy   = busy_q;
    assign tx.tx_done   = done_q;
    assign tx.tx_ack_ok = ack_q;
    assign tx.tx_error  = err_q;
    assign ps2k_clk_oe  = clk_oe_q;
    assign ps2k_data_oe = data_oe_q;

endmodule
